// File: rtl/ic_pkg.sv
// Shared interconnect constants: requester indices, outstanding depth and arbiter FSM encodings.
package ic_pkg;

    localparam int IC_MAX_OUTSTANDING = 4;

    localparam int IC_REQ_IMEM = 0;
    localparam int IC_REQ_DMEM = 1;

    typedef enum logic {
        IC_ARB_IDLE   = 1'b0,
        IC_ARB_LOCKED = 1'b1
    } ic_arb_state_e;

endpackage

// File: rtl/ic_req_arbiter_if.sv
// Requester-side and interconnect-side handshake of the request arbiter.
interface ic_req_arbiter_if #(
    parameter int NM = 2,
    parameter int W  = 64
);
    logic [NM-1:0]   m_req;
    logic [NM*W-1:0] m_data;
    logic [NM-1:0]   m_gnt;
    logic [NM-1:0]   m_rsp;
    logic            s_req;
    logic [W-1:0]    s_data;
    logic            s_gnt;
    logic            s_rsp;

    modport master (
        output m_req, m_data, s_gnt, s_rsp,
        input  m_gnt, m_rsp, s_req, s_data
    );

    modport slave (
        input  m_req, m_data, s_gnt, s_rsp,
        output m_gnt, m_rsp, s_req, s_data
    );
endinterface

// File: rtl/ic_rr_select.sv
// Round-robin first-set-bit finder: searches req upward from ptr with wrap.
// Purely combinational, zero latency, no backpressure of its own.
module ic_rr_select #(
    parameter int NM = 2
) (
    input  logic [NM-1:0]         req,
    input  logic [$clog2(NM)-1:0] ptr,
    output logic [NM-1:0]         onehot,
    output logic [$clog2(NM)-1:0] idx,
    output logic                  any
);
    always_comb begin
        int k;
        k      = 0;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 0; i < NM; i++) begin
            k = (int'(ptr) + i) % NM;
            if (!any && req[k]) begin
                any       = 1'b1;
                idx       = ($clog2(NM))'(k);
                onehot[k] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ic_req_arbiter.sv
// Round-robin request arbiter with lock-until-grant and in-order response routing via an ID FIFO.
// Request path is combinational; a full ID FIFO withholds s_req until a response frees a slot.
module ic_req_arbiter
    import ic_pkg::*;
#(
    parameter int NM              = 2,
    parameter int W               = 64,
    parameter int MAX_OUTSTANDING = IC_MAX_OUTSTANDING
) (
    input  logic                                 g_clk,
    input  logic                                 g_reset,
    ic_req_arbiter_if.slave                      bus,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 err_rsp
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int IDX_W = $clog2(NM);

    ic_arb_state_e     state_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  lock_sel_q;
    logic [NM-1:0]     fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              err_q;

    logic [NM-1:0]     rr_onehot;
    logic [IDX_W-1:0]  rr_idx;
    logic              rr_any;

    logic              full;
    logic [IDX_W-1:0]  cur_sel;
    logic [NM-1:0]     cur_onehot;
    logic              accept;
    logic              pop;

    ic_rr_select #(.NM(NM)) u_rr_select (
        .req    (bus.m_req),
        .ptr    (rr_ptr_q),
        .onehot (rr_onehot),
        .idx    (rr_idx),
        .any    (rr_any)
    );

    // Full is judged on the registered count only, so a same-cycle pop never enables a push.
    assign full = (count_q == CNT_W'(MAX_OUTSTANDING));

    always_comb begin
        cur_sel    = rr_idx;
        cur_onehot = rr_onehot;
        bus.s_req  = rr_any && !full;
        if (state_q == IC_ARB_LOCKED) begin
            cur_sel    = lock_sel_q;
            cur_onehot = NM'(1) << lock_sel_q;
            bus.s_req  = 1'b1;
        end
    end

    assign bus.s_data = bus.m_data[int'(cur_sel)*W +: W];
    assign accept     = bus.s_req && bus.s_gnt;
    assign bus.m_gnt  = cur_onehot & {NM{accept}};
    assign pop        = bus.s_rsp && (count_q != '0);
    assign bus.m_rsp  = pop ? fifo_q[tail_q] : '0;

    assign outstanding = count_q;
    assign err_rsp     = err_q;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q    <= IC_ARB_IDLE;
            rr_ptr_q   <= '0;
            lock_sel_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IC_ARB_IDLE: begin
                    if (bus.s_req && !bus.s_gnt) begin
                        state_q    <= IC_ARB_LOCKED;
                        lock_sel_q <= rr_idx;
                    end
                end
                IC_ARB_LOCKED: begin
                    if (bus.s_gnt) begin
                        state_q <= IC_ARB_IDLE;
                    end
                end
                default: state_q <= IC_ARB_IDLE;
            endcase

            if (accept) begin
                fifo_q[head_q] <= cur_onehot;
                head_q         <= head_q + PTR_W'(1);
                rr_ptr_q       <= (cur_sel == IDX_W'(NM - 1)) ? '0 : cur_sel + IDX_W'(1);
            end

            if (pop) begin
                tail_q <= tail_q + PTR_W'(1);
            end

            if (bus.s_rsp && (count_q == '0)) begin
                err_q <= 1'b1;
            end

            case ({accept, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_ic_req_arbiter.sv
// Directed table-driven bench for ic_req_arbiter plus a reset-while-locked sequence.
module tb_ic_req_arbiter;
    import ic_pkg::*;

    localparam int NM    = 2;
    localparam int W     = 64;
    localparam int MAXO  = 4;
    localparam int CNT_W = 3;
    localparam logic [W-1:0] D0 = 64'hA5A5_0000_1111_2222;
    localparam logic [W-1:0] D1 = 64'h5A5A_FFFF_3333_4444;

    logic             g_clk = 1'b0;
    logic             g_reset = 1'b1;
    logic [CNT_W-1:0] outstanding;
    logic             err_rsp;

    int checks = 0;
    int errors = 0;
    logic [NM-1:0] pend = '0;

    ic_req_arbiter_if #(.NM(NM), .W(W)) bus ();

    ic_req_arbiter #(.NM(NM), .W(W), .MAX_OUTSTANDING(MAXO)) dut (
        .g_clk       (g_clk),
        .g_reset     (g_reset),
        .bus         (bus.slave),
        .outstanding (outstanding),
        .err_rsp     (err_rsp)
    );

    always #5 g_clk = ~g_clk;

    assign bus.m_data = {D1, D0};

    typedef struct {
        logic [1:0] req;
        logic       gnt;
        logic       rsp;
        logic       e_sreq;
        int         e_sel;
        logic [1:0] e_gnt;
        logic [1:0] e_rsp;
        logic [2:0] e_out;
        logic       e_err;
    } vec_t;

    function automatic vec_t mk(logic [1:0] req, logic gnt, logic rsp, logic e_sreq, int e_sel,
                                logic [1:0] e_gnt, logic [1:0] e_rsp, logic [2:0] e_out, logic e_err);
        vec_t v;
        v.req = req; v.gnt = gnt; v.rsp = rsp; v.e_sreq = e_sreq; v.e_sel = e_sel;
        v.e_gnt = e_gnt; v.e_rsp = e_rsp; v.e_out = e_out; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge g_clk);
        if ((pend & ~v.req) != '0) begin
            errors++;
            $display("FAIL %s.protocol: m_req dropped before grant, pending 0x%0h, req 0x%0h", tag, pend, v.req);
        end
        bus.m_req = v.req;
        bus.s_gnt = v.gnt;
        bus.s_rsp = v.rsp;
        #2;
        chk({tag, ".s_req"}, 64'(bus.s_req), 64'(v.e_sreq));
        if (v.e_sreq) chk({tag, ".s_data"}, bus.s_data, (v.e_sel == IC_REQ_IMEM) ? D0 : D1);
        chk({tag, ".m_gnt"}, 64'(bus.m_gnt), 64'(v.e_gnt));
        chk({tag, ".m_rsp"}, 64'(bus.m_rsp), 64'(v.e_rsp));
        chk({tag, ".outstanding"}, 64'(outstanding), 64'(v.e_out));
        chk({tag, ".err_rsp"}, 64'(err_rsp), 64'(v.e_err));
        pend = bus.m_req & ~bus.m_gnt;
    endtask

    task automatic do_reset();
        @(negedge g_clk);
        g_reset   = 1'b1;
        bus.m_req = '0;
        bus.s_gnt = 1'b0;
        bus.s_rsp = 1'b0;
        pend      = '0;
        @(negedge g_clk);
        g_reset = 1'b0;
    endtask

    vec_t tbl_a[$];
    vec_t tbl_b[$];
    vec_t tbl_c[$];
    vec_t tbl_d[$];

    initial begin
        // Fill to full with alternating grants, pop while full, refill, drain, then an empty response.
        tbl_a.push_back(mk(2'b11, 1, 0, 1, 0, 2'b01, 2'b00, 3'd0, 0));
        tbl_a.push_back(mk(2'b11, 1, 0, 1, 1, 2'b10, 2'b00, 3'd1, 0));
        tbl_a.push_back(mk(2'b11, 1, 0, 1, 0, 2'b01, 2'b00, 3'd2, 0));
        tbl_a.push_back(mk(2'b11, 1, 0, 1, 1, 2'b10, 2'b00, 3'd3, 0));
        tbl_a.push_back(mk(2'b01, 1, 0, 0, 0, 2'b00, 2'b00, 3'd4, 0));
        tbl_a.push_back(mk(2'b01, 1, 1, 0, 0, 2'b00, 2'b01, 3'd4, 0));
        tbl_a.push_back(mk(2'b01, 1, 0, 1, 0, 2'b01, 2'b00, 3'd3, 0));
        tbl_a.push_back(mk(2'b00, 0, 1, 0, 0, 2'b00, 2'b10, 3'd4, 0));
        tbl_a.push_back(mk(2'b00, 0, 1, 0, 0, 2'b00, 2'b01, 3'd3, 0));
        tbl_a.push_back(mk(2'b00, 0, 1, 0, 0, 2'b00, 2'b10, 3'd2, 0));
        tbl_a.push_back(mk(2'b00, 0, 1, 0, 0, 2'b00, 2'b01, 3'd1, 0));
        tbl_a.push_back(mk(2'b00, 0, 1, 0, 0, 2'b00, 2'b00, 3'd0, 0));
        tbl_a.push_back(mk(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 3'd0, 1));

        // Lock on requester 0 while 1 joins, then issue order 0,1,1,0 and drain with a push+pop cycle.
        tbl_b.push_back(mk(2'b01, 0, 0, 1, 0, 2'b00, 2'b00, 3'd0, 0));
        tbl_b.push_back(mk(2'b11, 0, 0, 1, 0, 2'b00, 2'b00, 3'd0, 0));
        tbl_b.push_back(mk(2'b11, 0, 0, 1, 0, 2'b00, 2'b00, 3'd0, 0));
        tbl_b.push_back(mk(2'b11, 1, 0, 1, 0, 2'b01, 2'b00, 3'd0, 0));
        tbl_b.push_back(mk(2'b10, 1, 0, 1, 1, 2'b10, 2'b00, 3'd1, 0));
        tbl_b.push_back(mk(2'b10, 1, 0, 1, 1, 2'b10, 2'b00, 3'd2, 0));
        tbl_b.push_back(mk(2'b01, 1, 0, 1, 0, 2'b01, 2'b00, 3'd3, 0));
        tbl_b.push_back(mk(2'b00, 0, 1, 0, 0, 2'b00, 2'b01, 3'd4, 0));
        tbl_b.push_back(mk(2'b00, 0, 1, 0, 0, 2'b00, 2'b10, 3'd3, 0));
        tbl_b.push_back(mk(2'b00, 0, 1, 0, 0, 2'b00, 2'b10, 3'd2, 0));
        tbl_b.push_back(mk(2'b10, 1, 1, 1, 1, 2'b10, 2'b01, 3'd1, 0));
        tbl_b.push_back(mk(2'b00, 0, 1, 0, 0, 2'b00, 2'b10, 3'd1, 0));
        tbl_b.push_back(mk(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 3'd0, 0));

        // Two outstanding and a lock on requester 0, interrupted by reset.
        tbl_c.push_back(mk(2'b11, 1, 0, 1, 0, 2'b01, 2'b00, 3'd0, 0));
        tbl_c.push_back(mk(2'b11, 1, 0, 1, 1, 2'b10, 2'b00, 3'd1, 0));
        tbl_c.push_back(mk(2'b01, 0, 0, 1, 0, 2'b00, 2'b00, 3'd2, 0));

        // After reset: idle, free selection of requester 1, stale response flags an error.
        tbl_d.push_back(mk(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 3'd0, 0));
        tbl_d.push_back(mk(2'b10, 0, 0, 1, 1, 2'b00, 2'b00, 3'd0, 0));
        tbl_d.push_back(mk(2'b10, 1, 1, 1, 1, 2'b10, 2'b00, 3'd0, 0));
        tbl_d.push_back(mk(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 3'd1, 1));

        bus.m_req = '0;
        bus.s_gnt = 1'b0;
        bus.s_rsp = 1'b0;
        repeat (2) @(negedge g_clk);
        g_reset = 1'b0;
        #2;
        chk("rst.s_req", 64'(bus.s_req), 64'd0);
        chk("rst.m_gnt", 64'(bus.m_gnt), 64'd0);
        chk("rst.m_rsp", 64'(bus.m_rsp), 64'd0);
        chk("rst.outstanding", 64'(outstanding), 64'd0);
        chk("rst.err_rsp", 64'(err_rsp), 64'd0);

        foreach (tbl_a[i]) apply(tbl_a[i], $sformatf("a%0d", i));

        // err_rsp is sticky until reset.
        @(negedge g_clk);
        bus.m_req = '0;
        bus.s_gnt = 1'b0;
        bus.s_rsp = 1'b0;
        #2;
        chk("a.err_sticky", 64'(err_rsp), 64'd1);

        do_reset();
        #2;
        chk("rst2.err_rsp", 64'(err_rsp), 64'd0);
        foreach (tbl_b[i]) apply(tbl_b[i], $sformatf("b%0d", i));

        do_reset();
        foreach (tbl_c[i]) apply(tbl_c[i], $sformatf("c%0d", i));
        do_reset();
        #2;
        chk("c.rst.s_req", 64'(bus.s_req), 64'd0);
        chk("c.rst.outstanding", 64'(outstanding), 64'd0);
        foreach (tbl_d[i]) apply(tbl_d[i], $sformatf("d%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ic_req_arbiter.md
Name: ic_req_arbiter

Overview:
Shares one interconnect request channel between NM requesters (e.g. CPU instruction port, CPU data port, debug/DMA). Arbitration is round-robin, and the selection is locked until the downstream side grants. The block records the order in which requests were issued in a FIFO of one-hot requester IDs, and returns each in-order response to the requester that issued it. It sits between the masters and the interconnect address decoder, upstream of the per-device response tracking.

Parameters:
NM, 2, number of requesters; must be >= 2.
W, 64, request payload width per requester (address, write data, strobes, write enable, packed).
MAX_OUTSTANDING, 4, maximum issued-but-unanswered requests; must be a power of two, >= 2.
localparam PTR_W, $clog2(MAX_OUTSTANDING), FIFO pointer width.
localparam CNT_W, $clog2(MAX_OUTSTANDING+1), occupancy counter width.

Ports:
g_clk  in  1  clock; all state updates on the rising edge.
g_reset  in  1  synchronous, active-high reset.
m_req  in  NM  per-requester request valid.
m_data  in  NM*W  per-requester payload; requester i occupies bits [i*W +: W].
m_gnt  out  NM  one-hot; request i accepted this cycle.
m_rsp  out  NM  one-hot; the current response belongs to requester i.
s_req  out  1  request to interconnect.
s_data  out  W  payload of the selected requester.
s_gnt  in  1  interconnect accepts s_req this cycle.
s_rsp  in  1  interconnect returns one response this cycle (in issue order).
outstanding  out  CNT_W  current FIFO occupancy.
err_rsp  out  1  sticky flag: a response arrived with nothing outstanding.

Behaviour:
- Reset (g_reset high at an edge): FSM=IDLE, rr_ptr=0, FIFO head=tail=0, count=0, all FIFO entries 0, err_rsp=0.
  - All outputs are therefore 0 the cycle after reset: s_req=0, m_gnt=0, m_rsp=0, outstanding=0.
  - Reset mid-operation drops every in-flight record; responses arriving after reset raise err_rsp.
- The FSM has two states:
  - IDLE:
    - If |m_req and count<MAX_OUTSTANDING, sel = first set bit of m_req, searching from index rr_ptr upward with wrap.
    - s_req=1 and s_data=m_data[sel], combinationally in the same cycle.
    - If s_gnt is also high, the request is accepted and the FSM stays IDLE.
    - Otherwise lock_sel<=sel and FSM->LOCKED.
  - LOCKED:
    - s_req=1 and s_data=m_data[lock_sel], held stable until s_gnt.
    - m_req of other requesters does not change the selection.
    - On s_gnt the request is accepted and FSM->IDLE.
    - A requester must hold m_req and m_data stable until its m_gnt; the bench asserts this.
- Accept:
  - m_gnt = onehot(selected) & {NM{s_req & s_gnt}}.
  - The one-hot ID is pushed at FIFO[head]; head<=head+1 (wraps naturally, power-of-two depth).
  - rr_ptr<=selected+1, wrapping to 0 when it reaches NM.
- Full: when count==MAX_OUTSTANDING in IDLE, s_req=0 and no lock is taken.
  - LOCKED can only be entered with count<MAX, so a locked request is always pushable.
- Response:
  - When s_rsp and count>0: m_rsp=FIFO[tail], combinational, zero latency; tail<=tail+1.
  - When s_rsp and count==0: m_rsp=0, err_rsp<=1 (cleared only by reset), no pointer change.
- Simultaneous accept and response in the same cycle: push and pop both occur and count is unchanged.
  - When full, a pop this cycle does not enable a push this cycle; s_req depends on the registered count only.
- count: +1 on accept only, -1 on valid pop only; outstanding=count.

Decomposition:
- Shared package (ic_pkg): IC_MAX_OUTSTANDING default and requester index constants (IC_REQ_IMEM=0, IC_REQ_DMEM=1).
- Also in ic_pkg: FSM state encodings IC_ARB_IDLE=0, IC_ARB_LOCKED=1.
- One natural sub-module, ic_rr_select: combinational round-robin first-set-bit finder.
  - Inputs: req[NM], ptr. Outputs: onehot[NM], idx, any.

Test Plan:
- Reset then m_req=2'b11, s_gnt=1 every cycle -> m_gnt alternates 01,10,01,10; outstanding climbs 1,2,3,4, then s_req=0 while full.
- m_req=01 with s_gnt=0 for 3 cycles, m_req[1] asserted in cycle 2 -> s_req held 3 cycles with s_data=m_data[0]; cycle 4 s_gnt=1 -> m_gnt=01; next accept is requester 1.
- Issue order 0,1,1,0, then s_rsp on 4 consecutive cycles -> m_rsp = 01,10,10,01; outstanding 4->0.
- At outstanding=4, assert s_rsp together with m_req=01 -> pop occurs, m_rsp correct, no push that cycle; next cycle s_req=1 and accept -> outstanding returns to 4.
- s_rsp with outstanding=0 -> m_rsp=00 and err_rsp=1, which stays 1 until g_reset.
- With 2 outstanding and LOCKED, assert g_reset -> next cycle s_req=0, outstanding=0, FSM IDLE; a following s_rsp sets err_rsp.
